// File: rtl/spi_slave_pkg.sv
// +----------------------------------------------------------------------------+
// | spi_slave_pkg : shared types and constants for the SPI slave interface     |
// | Revision      : 1.0  initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4,
    ST_TX_WAIT   = 3'd5,
    ST_TX_SHIFT  = 3'd6
  } spi_state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // A frame is the two opcode bits followed by one address/data byte.
  function automatic int frame_width(input int addr_size);
    return addr_size + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_cnt.sv
// +----------------------------------------------------------------------------+
// | spi_shift_cnt : loadable down-counter with zero flag, used for rx and tx   |
// | Revision      : 1.0  initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_shift_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  // Saturates at zero so a long-held select line can never wrap the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/spi_slave_if.sv
// +----------------------------------------------------------------------------+
// | spi_slave_if : SPI frame decoder / read-byte serialiser for command RAM    |
// | Option       : SPI_FRAME_ERR_EN adds a frame_err abort strobe             |
// | Revision     : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int c_frame_w = frame_width(ADDR_SIZE);
  localparam int c_cnt_w   = $clog2(c_frame_w);

  spi_state_t             r_state;
  logic                   r_rd_addr_seen;
  logic                   r_frame_done;
  logic [c_frame_w-1:0]   r_rx_shift;
  logic [ADDR_SIZE-1:0]   r_tx_shift;

  logic                   w_cnt_load;
  logic                   w_cnt_dec;
  logic [c_cnt_w-1:0]     w_cnt_val;
  logic [c_cnt_w-1:0]     w_cnt;
  logic                   w_cnt_done;

  // Both paths count ADDR_SIZE bits after their setup cycle.
  assign w_cnt_val = c_cnt_w'(ADDR_SIZE);

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_CHK_CMD:                           w_cnt_load = 1'b1;
      ST_WRITE, ST_READ_ADD, ST_READ_DATA:  w_cnt_dec  = 1'b1;
      ST_TX_WAIT:                           w_cnt_load = tx_valid;
      ST_TX_SHIFT:                          w_cnt_dec  = 1'b1;
      default: ;
    endcase
  end

  spi_shift_cnt #(
    .WIDTH    (c_cnt_w)
  ) u_shift_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .count    (w_cnt),
    .done     (w_cnt_done)
  );

`ifdef SPI_FRAME_ERR_EN
  logic w_incomplete;
  assign w_incomplete = !((r_state == ST_TX_SHIFT) && w_cnt_done);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_rd_addr_seen <= 1'b0;
      r_frame_done   <= 1'b0;
      r_rx_shift     <= '0;
      r_tx_shift     <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      MISO           <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err      <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      // A completed write/address frame blocks re-entry until select is released.
      if (SS_n) begin
        r_frame_done <= 1'b0;
      end

      if ((r_state != ST_IDLE) && SS_n) begin
        r_state <= ST_IDLE;
        MISO    <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
        frame_err <= w_incomplete;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!SS_n && !r_frame_done) begin
              r_state <= ST_CHK_CMD;
            end
          end

          ST_CHK_CMD: begin
            r_rx_shift <= {r_rx_shift[c_frame_w-2:0], MOSI};
            if (!MOSI) begin
              r_state <= ST_WRITE;
            end else if (r_rd_addr_seen) begin
              r_state <= ST_READ_DATA;
            end else begin
              r_state <= ST_READ_ADD;
            end
          end

          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            r_rx_shift <= {r_rx_shift[c_frame_w-2:0], MOSI};
            if (w_cnt_done) begin
              rx_data  <= {r_rx_shift[c_frame_w-2:0], MOSI};
              rx_valid <= 1'b1;
              if (r_state == ST_READ_DATA) begin
                r_rd_addr_seen <= 1'b0;
                r_state        <= ST_TX_WAIT;
              end else begin
                if (r_state == ST_READ_ADD) begin
                  r_rd_addr_seen <= 1'b1;
                end
                r_frame_done <= 1'b1;
                r_state      <= ST_IDLE;
              end
            end
          end

          ST_TX_WAIT: begin
            if (tx_valid) begin
              r_tx_shift <= tx_data;
              r_state    <= ST_TX_SHIFT;
            end
          end

          ST_TX_SHIFT: begin
            if (!w_cnt_done) begin
              MISO       <= r_tx_shift[ADDR_SIZE-1];
              r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
            end else begin
              MISO <= 1'b0;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_if.sv
// +----------------------------------------------------------------------------+
// | tb_spi_slave_if : directed self-checking bench for spi_slave_if            |
// | Option          : SPI_FRAME_ERR_EN also checks the frame_err strobe        |
// | Revision        : 1.0  initial release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_slave_if;
  import spi_slave_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  spi_slave_if #(
    .ADDR_SIZE (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    SS_n = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    tick();
  endtask

  task automatic shift_bits(input logic [9:0] bits, input int n);
    for (int i = 9; i > 9 - n; i--) begin
      MOSI = bits[i];
      tick();
      if (rx_valid) pulses++;
    end
  endtask

  task automatic check_miso_byte(input string tag, input logic [7:0] exp_byte);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("%s_bit%0d", tag, k), MISO, exp_byte[7-k]);
    end
  endtask

  initial begin
    int wait_bad;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(); tick();
    check("rst_state", dut.r_state, ST_IDLE);
    check("rst_miso", MISO, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_seen", dut.r_rd_addr_seen, 0);
`ifdef SPI_FRAME_ERR_EN
    check("rst_frame_err", frame_err, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Write frame, SS_n held low afterwards must not restart a frame
    pulses = 0;
    start_frame();
    shift_bits(10'b00_1010_0101, 10);
    check("wr_rx_valid", rx_valid, 1);
    check("wr_rx_data", rx_data, 10'h0A5);
    check("wr_state", dut.r_state, ST_IDLE);
    tick();
    if (rx_valid) pulses++;
    check("wr_no_restart", dut.r_state, ST_IDLE);
    end_frame();
    check("wr_pulses", pulses, 1);
    check("wr_idle", dut.r_state, ST_IDLE);

    // Read address then read data, RAM answers with C3
    start_frame();
    shift_bits(10'b10_0000_0011, 10);
    check("ra_rx_data", rx_data, 10'h203);
    check("ra_seen", dut.r_rd_addr_seen, 1);
    check("ra_state", dut.r_state, ST_IDLE);
    end_frame();
    start_frame();
    shift_bits(10'b11_0000_0000, 10);
    check("rd_rx_valid", rx_valid, 1);
    check("rd_rx_data", rx_data, 10'h300);
    check("rd_state", dut.r_state, ST_TX_WAIT);
    check("rd_seen", dut.r_rd_addr_seen, 0);
    tick();
    check("rd_miso_wait", MISO, 0);
    tx_valid = 1'b1; tx_data = 8'hC3;
    tick();
    tx_valid = 1'b0;
    check_miso_byte("rd_c3", 8'hC3);
    tick();
    check("rd_miso_after", MISO, 0);
    check("rd_hold_shift", dut.r_state, ST_TX_SHIFT);
    end_frame();
    check("rd_end_idle", dut.r_state, ST_IDLE);

    // Read-data opcode without a prior address frame decodes as address
    start_frame();
    shift_bits(10'b11_0101_0101, 10);
    check("rna_rx_valid", rx_valid, 1);
    check("rna_rx_data", rx_data, 10'h355);
    check("rna_state", dut.r_state, ST_IDLE);
    check("rna_seen", dut.r_rd_addr_seen, 1);
    end_frame();

    // Long TX_WAIT, then RAM answers with 81
    start_frame();
    shift_bits(10'b11_1111_0000, 10);
    check("tw_rx_data", rx_data, 10'h3F0);
    check("tw_state", dut.r_state, ST_TX_WAIT);
    wait_bad = 0;
    repeat (20) begin
      tick();
      if (MISO !== 1'b0 || dut.r_state !== ST_TX_WAIT) wait_bad++;
    end
    check("tw_idle_miso", wait_bad, 0);
    tx_valid = 1'b1; tx_data = 8'h81;
    tick();
    tx_valid = 1'b0;
    check_miso_byte("tw_81", 8'h81);
    end_frame();

    // Abort after 5 bits
    pulses = 0;
    start_frame();
    shift_bits(10'b00_1111_1111, 5);
    SS_n = 1'b1;
    tick();
    if (rx_valid) pulses++;
    check("ab_state", dut.r_state, ST_IDLE);
    check("ab_rx_data", rx_data, 10'h3F0);
    check("ab_seen", dut.r_rd_addr_seen, 0);
`ifdef SPI_FRAME_ERR_EN
    check("ab_frame_err", frame_err, 1);
`endif
    tick();
    if (rx_valid) pulses++;
    check("ab_pulses", pulses, 0);
`ifdef SPI_FRAME_ERR_EN
    check("ab_frame_err_end", frame_err, 0);
`endif

    // Reset in the middle of a read-data frame
    start_frame();
    shift_bits(10'b10_0000_0001, 10);
    end_frame();
    start_frame();
    shift_bits(10'b11_1010_1010, 4);
    check("rr_pre_state", dut.r_state, ST_READ_DATA);
    rst_n = 1'b0;
    tick();
    check("rr_state", dut.r_state, ST_IDLE);
    check("rr_miso", MISO, 0);
    check("rr_rx_valid", rx_valid, 0);
    check("rr_seen", dut.r_rd_addr_seen, 0);
    rst_n = 1'b1; SS_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
